// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ro_meter_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  localparam int N_CH_DEF        = 16;
  localparam int SEL_W_DEF       = 4;
  localparam int WIN_W_DEF       = 16;
  localparam int CNT_W_DEF       = 24;
  localparam int SYNC_STAGES_DEF = 2;

  // Cycles spent flushing the synchroniser after a channel switch:
  // the flop chain plus the edge-detect register.
  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronises one asynchronous RO output into wb_clk_i and flags rising edges.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic async_in,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flop chain and previous-value register for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// RO output mux with on-chip frequency measurement and channel scan.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SEL_W       = SEL_W_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [N_CH-1:0]  ro_in,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [WIN_W-1:0] window,
  input  logic             scan,
  input  logic             start,
  input  logic             abort,
  output logic             ro_mux_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic [SEL_W-1:0] result_ch,
  output logic             overflow
);

  localparam int               SETTLE_N = settle_cycles(SYNC_STAGES);
  localparam int               ST_W     = $clog2(SETTLE_N + 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_cnt_q;
  logic [ST_W-1:0]  settle_cnt_q;
  logic             scan_q;
  logic [SEL_W-1:0] cur_ch;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ovf_q, ovf_nxt;
  logic             ro_sel, ro_edge;
  logic             accept, settle_end, last_win, more;

  // Pad pass-through follows ch_sel directly; out-of-range channels read 0
  always_comb begin
    ro_mux_o = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (ch_sel == SEL_W'(i)) ro_mux_o = ro_in[i];
  end

  // Measurement mux follows the registered channel so a run is immune to ch_sel
  always_comb begin
    ro_sel = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (cur_ch == SEL_W'(i)) ro_sel = ro_in[i];
  end

  ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .async_in (ro_sel),
    .edge_o   (ro_edge)
  );

  // Saturating edge count; overflow flags an edge lost at all-ones
  always_comb begin
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (ro_edge) begin
      if (&cnt_q) ovf_nxt = 1'b1;
      else        cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  assign accept     = start && (window != '0);
  assign settle_end = (settle_cnt_q == ST_W'(SETTLE_N - 1));
  assign last_win   = (win_cnt_q == WIN_W'(1));
  assign more       = scan_q && (cur_ch != LAST_CH);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = SETTLE;
      SETTLE:  if (settle_end) state_d = MEASURE;
      MEASURE: if (last_win)   state_d = REPORT;
      REPORT:  state_d = more ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Outputs decoded from state; results are captured on entry to REPORT
  // so done and result appear in the same cycle
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == REPORT);
  end

  // Run configuration, settle/window counters and edge counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      win_q        <= '0;
      scan_q       <= 1'b0;
      cur_ch       <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + ST_W'(1) : '0;
      case (state_q)
        IDLE: if (accept && !abort) begin
          win_q  <= window;
          scan_q <= scan;
          cur_ch <= scan ? '0 : ch_sel;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end
        SETTLE:  win_cnt_q <= win_q;
        MEASURE: begin
          win_cnt_q <= win_cnt_q - WIN_W'(1);
          cnt_q     <= cnt_nxt;
          ovf_q     <= ovf_nxt;
        end
        REPORT: if (more && !abort) begin
          cur_ch <= cur_ch + SEL_W'(1);
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Result registers; an aborted measurement leaves them untouched
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      result    <= '0;
      result_ch <= '0;
      overflow  <= 1'b0;
    end else if (state_q == MEASURE && last_win && !abort) begin
      result    <= cnt_nxt;
      result_ch <= cur_ch;
      overflow  <= ovf_nxt;
    end
  end

endmodule
